// File: rtl/mem_access_unit_if.sv
// Request/response channel between the execute/memory stage (master) and
// the memory access unit (slave).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] byte_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err;

  modport master (
    output req_valid, op_store, op_size, op_unsigned, byte_addr, store_data,
    input  req_ready, load_data, load_valid, addr_err
  );

  modport slave (
    input  req_valid, op_store, op_size, op_unsigned, byte_addr, store_data,
    output req_ready, load_data, load_valid, addr_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS byte/half/word access unit over a word-only RAM; sub-word stores use a
// two-cycle read-modify-write. MEM_ALIGN_CHECK_EN enables misalignment errors.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [31:0]           cap_word;
  logic [1:0]            cap_lane;
  logic                  cap_is_byte;
  logic [15:0]           cap_data;
  logic [31:0]           load_data_q;
  logic                  load_valid_q;
  logic                  addr_err_q;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [1:0]            eff_size;
  logic [1:0]            eff_lane;
  logic                  err;
  logic                  is_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           ext_data;
  logic [31:0]           merged;
  logic                  unused_addr_bits;

  // Upper address bits fold away: addresses wrap modulo the RAM size.
  assign unused_addr_bits = ^bus.byte_addr[31:ADDR_WIDTH+2];
  assign word_idx         = bus.byte_addr[ADDR_WIDTH+1:2];
  assign lane             = bus.byte_addr[1:0];
  assign bus.req_ready    = (state == IDLE) && !rst;
  assign accept           = bus.req_valid && bus.req_ready;
  assign is_word          = (eff_size == 2'b10);

  always_comb begin
    eff_size = bus.op_size;
    eff_lane = lane;
    err      = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (bus.op_size)
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
`else
    // Without checking, misaligned accesses are forced onto their natural
    // boundary and the reserved size behaves as a word access.
    case (bus.op_size)
      2'b01: eff_lane = {lane[1], 1'b0};
      2'b10, 2'b11: begin
        eff_size = 2'b10;
        eff_lane = 2'b00;
      end
      default: eff_lane = lane;
    endcase
`endif
  end

  always_comb begin
    sel_byte = ram_rdata[{eff_lane, 3'b000} +: 8];
    sel_half = ram_rdata[{eff_lane[1], 4'b0000} +: 16];
    case (eff_size)
      2'b00:   ext_data = {{24{!bus.op_unsigned && sel_byte[7]}}, sel_byte};
      2'b01:   ext_data = {{16{!bus.op_unsigned && sel_half[15]}}, sel_half};
      default: ext_data = ram_rdata;
    endcase
  end

  always_comb begin
    merged = cap_word;
    if (cap_is_byte)
      merged[{cap_lane, 3'b000} +: 8] = cap_data[7:0];
    else
      merged[{cap_lane[1], 4'b0000} +: 16] = cap_data;
  end

  // A pending RMW write is suppressed while reset is asserted.
  always_comb begin
    if (state == RMW_WR) begin
      ram_addr  = cap_idx;
      ram_wdata = merged;
      ram_we    = !rst;
    end else begin
      ram_addr  = word_idx;
      ram_wdata = bus.store_data;
      ram_we    = accept && bus.op_store && is_word && !err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      cap_idx      <= '0;
      cap_word     <= '0;
      cap_lane     <= '0;
      cap_is_byte  <= 1'b0;
      cap_data     <= '0;
    end else begin
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (err) begin
              addr_err_q <= 1'b1;
            end else if (!bus.op_store) begin
              load_data_q  <= ext_data;
              load_valid_q <= 1'b1;
            end else if (!is_word) begin
              cap_idx     <= word_idx;
              cap_word    <= ram_rdata;
              cap_lane    <= eff_lane;
              cap_is_byte <= (eff_size == 2'b00);
              cap_data    <= bus.store_data[15:0];
              state       <= RMW_WR;
            end
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_data  = load_data_q;
  assign bus.load_valid = load_valid_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// loads/writes/errors; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  localparam int K_NONE = 0;
  localparam int K_LOAD = 1;
  localparam int K_WRITE = 2;
  localparam int K_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] ram [0:1023];

  logic [31:0] lq[$];
  wr_t         wq[$];
  int          err_pending = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] last_load = 32'h0;

  mem_access_unit_if bus ();

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[8] = 32'h5A5A5A5A;
  end

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Monitor: compares every observed RAM write, load response and error pulse
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) begin
        checkOutput("unexpected_write", {31'b0, ram_we}, 32'h0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        checkOutput("ram_write_addr", {22'b0, ram_addr}, {22'b0, w.a});
        checkOutput("ram_write_data", ram_wdata, w.d);
      end
    end
    if (bus.load_valid === 1'b1) begin
      if (lq.size() == 0) checkOutput("unexpected_load", {31'b0, bus.load_valid}, 32'h0);
      else checkOutput("load_data", bus.load_data, lq.pop_front());
    end
    if (bus.addr_err === 1'b1) begin
      checkOutput("addr_err_expected", {31'b0, bus.addr_err}, (err_pending > 0) ? 32'h1 : 32'h0);
      if (err_pending > 0) err_pending--;
    end
  end

  task automatic applyStimulus(input bit st, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int kind, input logic [9:0] ea, input logic [31:0] ev);
    int waited;
    wr_t w;
    case (kind)
      K_LOAD: begin lq.push_back(ev); last_load = ev; end
      K_WRITE: begin w.a = ea; w.d = ev; wq.push_back(w); end
      K_ERR: err_pending++;
      default: ;
    endcase
    bus.op_store    = st;
    bus.op_size     = sz;
    bus.op_unsigned = uns;
    bus.byte_addr   = addr;
    bus.store_data  = data;
    bus.req_valid   = 1'b1;
    waited = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready !== 1'b1) checkOutput("req_ready_timeout", {31'b0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.op_store    = 1'b0;
    bus.op_size     = 2'b00;
    bus.op_unsigned = 1'b0;
    bus.byte_addr   = 32'h0;
    bus.store_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, bus.req_ready}, 32'h1);
    checkOutput("reset_load_valid", {31'b0, bus.load_valid}, 32'h0);
    checkOutput("reset_load_data", bus.load_data, 32'h0);
    checkOutput("reset_addr_err", {31'b0, bus.addr_err}, 32'h0);
    nextCycle();

    // Word store / load and lane extraction
    applyStimulus(1, 2'b10, 0, 32'h10, 32'h11223344, K_WRITE, 10'd4, 32'h11223344);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'h11223344);
    applyStimulus(0, 2'b00, 0, 32'h13, 32'h0, K_LOAD, 10'd0, 32'h00000011);

    // Sub-word read-modify-write
    applyStimulus(1, 2'b00, 0, 32'h11, 32'h000000AB, K_WRITE, 10'd4, 32'h1122AB44);
    @(negedge clk);
    checkOutput("rmw_req_ready", {31'b0, bus.req_ready}, 32'h0);
    nextCycle();
    applyStimulus(1, 2'b01, 0, 32'h12, 32'h0000BEEF, K_WRITE, 10'd4, 32'hBEEFAB44);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'hBEEFAB44);

    // Sign and zero extension
    applyStimulus(1, 2'b10, 0, 32'h10, 32'h80FF0000, K_WRITE, 10'd4, 32'h80FF0000);
    applyStimulus(0, 2'b00, 0, 32'h12, 32'h0, K_LOAD, 10'd0, 32'hFFFFFFFF);
    applyStimulus(0, 2'b00, 1, 32'h12, 32'h0, K_LOAD, 10'd0, 32'h000000FF);
    applyStimulus(0, 2'b01, 0, 32'h12, 32'h0, K_LOAD, 10'd0, 32'hFFFF80FF);
    applyStimulus(0, 2'b01, 1, 32'h12, 32'h0, K_LOAD, 10'd0, 32'h000080FF);
    applyStimulus(0, 2'b00, 0, 32'h13, 32'h0, K_LOAD, 10'd0, 32'hFFFFFF80);
    applyStimulus(0, 2'b00, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'h00000000);

`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(0, 2'b10, 0, 32'h12, 32'h0, K_ERR, 10'd0, 32'h0);
    @(negedge clk);
    checkOutput("err_load_data_held", bus.load_data, last_load);
    nextCycle();
    applyStimulus(1, 2'b01, 0, 32'h13, 32'h00001234, K_ERR, 10'd0, 32'h0);
    applyStimulus(0, 2'b11, 0, 32'h10, 32'h0, K_ERR, 10'd0, 32'h0);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'h80FF0000);
`else
    applyStimulus(0, 2'b10, 0, 32'h12, 32'h0, K_LOAD, 10'd0, 32'h80FF0000);
    applyStimulus(0, 2'b01, 0, 32'h13, 32'h0, K_LOAD, 10'd0, 32'hFFFF80FF);
    applyStimulus(0, 2'b11, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'h80FF0000);
    applyStimulus(1, 2'b01, 0, 32'h13, 32'h00001234, K_WRITE, 10'd4, 32'h12340000);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, K_LOAD, 10'd0, 32'h12340000);
    @(negedge clk);
    checkOutput("addr_err_tied", {31'b0, bus.addr_err}, 32'h0);
    nextCycle();
`endif

    // Reset during the RMW write cycle drops the write
    applyStimulus(1, 2'b00, 0, 32'h20, 32'h00000077, K_NONE, 10'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_rmw_we", {31'b0, ram_we}, 32'h0);
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    checkOutput("post_rst_load_valid", {31'b0, bus.load_valid}, 32'h0);
    checkOutput("post_rst_load_data", bus.load_data, 32'h0);
    nextCycle();
    applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, K_LOAD, 10'd0, 32'h5A5A5A5A);

    // Address wrap and RMW on the wrapped word
    applyStimulus(1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, K_WRITE, 10'd0, 32'hCAFEF00D);
    applyStimulus(0, 2'b10, 0, 32'h0, 32'h0, K_LOAD, 10'd0, 32'hCAFEF00D);
    applyStimulus(1, 2'b00, 0, 32'h3, 32'h00000099, K_WRITE, 10'd0, 32'h99FEF00D);
    nextCycle();
    applyStimulus(0, 2'b00, 1, 32'h3, 32'h0, K_LOAD, 10'd0, 32'h00000099);
    applyStimulus(0, 2'b01, 0, 32'h0, 32'h0, K_LOAD, 10'd0, 32'hFFFFF00D);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("pending_loads", lq.size(), 32'h0);
    checkOutput("pending_writes", wq.size(), 32'h0);
    checkOutput("pending_errors", err_pending, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
